// File: rtl/seq_write.sv
// seq_write: sequence recorder. Appends one entry per w_en strobe at the
// running index, supports clear, undo (pop last) and replace-last, and offers
// a registered random-access read port with a hit flag.
module seq_write #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    input  logic              undo,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_hit,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [DATA_W-1:0] last
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL
    } state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_hit_q;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] tail_idx;
    state_e            state;

    // Index of the most recent valid entry (wraps to DEPTH-1 when full).
    assign tail_idx = count_q[ADDR_W-1:0] - ADDR_W'(1);

    // State register: count and its companions, plus the read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
            pend_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_hit_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            rd_data_q  <= mem[rd_addr];
            rd_hit_q   <= ({1'b0, rd_addr} < count_q);
        end
    end

    // RAM write port; contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[waddr] <= w_data;
        end
    end

    // Next-state: clr beats everything, then replace/append/undo. After an
    // undo, last is refreshed one cycle later from the new tail so the RAM
    // lookup uses the already-decremented count.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        last_d     = last_q;
        pend_d     = 1'b0;
        we         = 1'b0;
        waddr      = count_q[ADDR_W-1:0];
        if (clr) begin
            count_d    = '0;
            overflow_d = 1'b0;
            last_d     = '0;
        end else if (w_en && undo && state != ST_EMPTY) begin
            we     = 1'b1;
            waddr  = tail_idx;
            last_d = w_data;
        end else if (w_en) begin
            if (state == ST_FULL) begin
                overflow_d = 1'b1;
            end else begin
                we      = 1'b1;
                count_d = count_q + (ADDR_W+1)'(1);
                last_d  = w_data;
            end
        end else if (undo && state != ST_EMPTY) begin
            count_d = count_q - (ADDR_W+1)'(1);
            pend_d  = 1'b1;
        end else if (pend_q) begin
            last_d = (state == ST_EMPTY) ? '0 : mem[tail_idx];
        end
    end

    // Output decode: occupancy state derived from the registered count.
    always_comb begin
        if (count_q == '0) begin
            state = ST_EMPTY;
        end else if (count_q == DEPTH_C) begin
            state = ST_FULL;
        end else begin
            state = ST_FILLING;
        end
        empty    = (state == ST_EMPTY);
        full     = (state == ST_FULL);
        count    = count_q;
        overflow = overflow_q;
        last     = last_q;
        rd_data  = rd_data_q;
        rd_hit   = rd_hit_q;
    end

endmodule

// File: tb/tb_seq_write.sv
// Directed self-checking bench for seq_write.
module tb_seq_write;

    logic        clk = 1'b0;
    logic        rst, clr, w_en, undo;
    logic [11:0] w_data;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data, last;
    logic        rd_hit, empty, full, overflow;
    logic [8:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    seq_write #(.DATA_W(12), .DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .w_data(w_data),
        .undo(undo), .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
        .count(count), .empty(empty), .full(full), .overflow(overflow),
        .last(last)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        clr = 0; w_en = 0; undo = 0; rst = 0;
    endtask

    task automatic push(input logic [11:0] d);
        w_en = 1; w_data = d; step(); w_en = 0;
    endtask

    task automatic test_reset();
        rst = 1; clr = 0; w_en = 0; undo = 0; w_data = '0; rd_addr = '0;
        step(); step();
        n_tests++; if (count !== 9'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
        n_tests++; if (overflow !== 1'b0 || last !== 12'h000) begin n_fail++; $display("FAIL reset_ovf_last got %b/%h exp 0/000", overflow, last); end
        n_tests++; if (rd_data !== 12'h000 || rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_read got %h/%b exp 000/0", rd_data, rd_hit); end
        rst = 0;
    endtask

    task automatic test_append_read();
        push(12'h00A); push(12'h00B); push(12'h00C);
        n_tests++; if (count !== 9'd3 || last !== 12'h00C) begin n_fail++; $display("FAIL append got count=%0d last=%h exp 3/00C", count, last); end
        rd_addr = 8'd1; step();
        n_tests++; if (rd_data !== 12'h00B || rd_hit !== 1'b1) begin n_fail++; $display("FAIL read1 got %h/%b exp 00B/1", rd_data, rd_hit); end
        rd_addr = 8'd3; step();
        n_tests++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL read_miss got hit=%b exp 0", rd_hit); end
    endtask

    task automatic test_undo();
        undo = 1; step(); undo = 0;
        n_tests++; if (count !== 9'd2) begin n_fail++; $display("FAIL undo1_count got %0d exp 2", count); end
        step();
        n_tests++; if (last !== 12'h00B) begin n_fail++; $display("FAIL undo1_last got %h exp 00B", last); end
        undo = 1; step(); step(); undo = 0; step();
        n_tests++; if (empty !== 1'b1 || count !== 9'd0 || last !== 12'h000) begin n_fail++; $display("FAIL undo_empty got e=%b c=%0d last=%h exp 1/0/000", empty, count, last); end
        undo = 1; step(); undo = 0; step();
        n_tests++; if (count !== 9'd0 || overflow !== 1'b0 || last !== 12'h000) begin n_fail++; $display("FAIL undo_extra got c=%0d o=%b last=%h exp 0/0/000", count, overflow, last); end
    endtask

    task automatic test_replace();
        push(12'h0A1); push(12'h0A2);
        w_en = 1; undo = 1; w_data = 12'h123; step(); w_en = 0; undo = 0;
        n_tests++; if (count !== 9'd2 || last !== 12'h123) begin n_fail++; $display("FAIL replace got c=%0d last=%h exp 2/123", count, last); end
        rd_addr = 8'd1; step();
        n_tests++; if (rd_data !== 12'h123) begin n_fail++; $display("FAIL replace_mem1 got %h exp 123", rd_data); end
        rd_addr = 8'd0; step();
        n_tests++; if (rd_data !== 12'h0A1) begin n_fail++; $display("FAIL replace_mem0 got %h exp 0A1", rd_data); end
        clr = 1; step(); clr = 0;
        w_en = 1; undo = 1; w_data = 12'h456; step(); w_en = 0; undo = 0;
        n_tests++; if (count !== 9'd1 || last !== 12'h456) begin n_fail++; $display("FAIL replace_empty got c=%0d last=%h exp 1/456", count, last); end
        rd_addr = 8'd0; step();
        n_tests++; if (rd_data !== 12'h456 || rd_hit !== 1'b1) begin n_fail++; $display("FAIL replace_empty_mem got %h/%b exp 456/1", rd_data, rd_hit); end
    endtask

    task automatic test_fill_overflow();
        clr = 1; step(); clr = 0;
        for (int i = 0; i < 256; i++) push(12'h800 | 12'(i));
        n_tests++; if (full !== 1'b1 || count !== 9'd256 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill got f=%b c=%0d o=%b exp 1/256/0", full, count, overflow); end
        push(12'hFFF);
        n_tests++; if (overflow !== 1'b1 || count !== 9'd256 || last !== 12'h8FF) begin n_fail++; $display("FAIL overflow got o=%b c=%0d last=%h exp 1/256/8FF", overflow, count, last); end
        rd_addr = 8'd0; step();
        n_tests++; if (rd_data !== 12'h800) begin n_fail++; $display("FAIL entry0_kept got %h exp 800", rd_data); end
        w_en = 1; undo = 1; w_data = 12'h321; step(); w_en = 0; undo = 0;
        n_tests++; if (overflow !== 1'b1 || count !== 9'd256 || last !== 12'h321) begin n_fail++; $display("FAIL replace_full got o=%b c=%0d last=%h exp 1/256/321", overflow, count, last); end
        step();
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        clr = 1; step(); clr = 0;
        n_tests++; if (count !== 9'd0 || overflow !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || last !== 12'h000) begin n_fail++; $display("FAIL clr got c=%0d o=%b e=%b f=%b last=%h exp 0/0/1/0/000", count, overflow, empty, full, last); end
    endtask

    task automatic test_read_first();
        for (int i = 0; i < 4; i++) push(12'h010 + 12'(i));
        rd_addr = 8'd4; w_en = 1; w_data = 12'h055; step(); w_en = 0;
        n_tests++; if (rd_data !== 12'h804 || rd_hit !== 1'b0) begin n_fail++; $display("FAIL read_first got %h/%b exp 804/0", rd_data, rd_hit); end
        step();
        n_tests++; if (rd_data !== 12'h055 || rd_hit !== 1'b1) begin n_fail++; $display("FAIL read_after got %h/%b exp 055/1", rd_data, rd_hit); end
    endtask

    task automatic test_clr_rst();
        clr = 1; w_en = 1; w_data = 12'h777; step(); clr = 0; w_en = 0;
        n_tests++; if (count !== 9'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL clr_wen got c=%0d e=%b exp 0/1", count, empty); end
        rd_addr = 8'd0; step();
        n_tests++; if (rd_data !== 12'h010 || rd_hit !== 1'b0) begin n_fail++; $display("FAIL clr_nowrite got %h/%b exp 010/0", rd_data, rd_hit); end
        push(12'h3A1); push(12'h3A2);
        rd_addr = 8'd1; rst = 1; w_en = 1; w_data = 12'h3A3; step(); rst = 0; w_en = 0;
        n_tests++; if (count !== 9'd0 || overflow !== 1'b0 || last !== 12'h000 || rd_data !== 12'h000 || rd_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid got c=%0d o=%b last=%h rd=%h hit=%b exp all 0", count, overflow, last, rd_data, rd_hit); end
        push(12'h3AB);
        rd_addr = 8'd0; step();
        n_tests++; if (rd_data !== 12'h3AB || rd_hit !== 1'b1 || count !== 9'd1) begin n_fail++; $display("FAIL rst_restart got %h/%b c=%0d exp 3AB/1/1", rd_data, rd_hit, count); end
    endtask

    initial begin
        idle();
        w_data = '0; rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_append_read();
        test_undo();
        test_replace();
        test_fill_overflow();
        test_read_first();
        test_clr_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
